// File: rtl/aer_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aer_frame_sequencer
//  Purpose  : Captures an AER frame into an on-chip buffer, replays it to an
//             SCNN core over valid/ready, then waits for the classifier result.
//  Revision : 1.0  initial release
// ============================================================================
module aer_frame_sequencer #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 14,
   parameter int CLASS_W     = 2,
   parameter int NUM_CLASSES = 3,
   parameter int RESULT_W    = 32,
   parameter int DEDUP       = 1,
   parameter int TIMEOUT     = 65535
) (
   input  logic                work_clk,
   input  logic                rst,
   input  logic                aer_valid_i,
   input  logic [DATA_W-1:0]   aer_data_i,
   output logic                core_rst_o,
   output logic                prop_en_o,
   output logic [DATA_W-1:0]   core_aer_o,
   output logic                core_aer_valid_o,
   input  logic                core_ready_i,
   input  logic                class_valid_i,
   input  logic [CLASS_W-1:0]  class_id_i,
   output logic [RESULT_W-1:0] result_o,
   output logic                result_valid_o,
   output logic [ADDR_W:0]     event_count_o,
   output logic                overflow_o,
   output logic                timeout_o,
   output logic                busy_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int c_ncls = (NUM_CLASSES > (1 << CLASS_W)) ? (1 << CLASS_W) : NUM_CLASSES;
   localparam logic [CLASS_W:0] c_ncls_v  = (CLASS_W + 1)'(c_ncls);
   localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] c_tmr_end = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CAPTURE  = 3'd1,
      ST_REPLAY   = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_OUT      = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_ram_q;
   logic [CNT_W-1:0]    r_count;
   logic [DATA_W-1:0]   r_last;
   logic                r_overflow;
   logic                r_timeout;
   logic [RESULT_W-1:0] r_result;
   logic [TMR_W-1:0]    r_timer;
   logic [CNT_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_xfer_cnt;
   logic                r_rd_pend;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;

   logic                w_start;
   logic                w_dup;
   logic                w_full;
   logic                w_cap_acc;
   logic                w_cap_ovf;
   logic                w_ram_we;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic                w_xfer;
   logic                w_last_xfer;
   logic                w_rd_issue;
   logic                w_class_ok;
   logic                w_timer_done;

   assign w_start      = (r_state == ST_IDLE) && aer_valid_i;
   assign w_dup        = (DEDUP != 0) && (aer_data_i == r_last);
   assign w_full       = (r_count == c_depth);
   assign w_cap_acc    = (r_state == ST_CAPTURE) && aer_valid_i && !w_dup && !w_full;
   assign w_cap_ovf    = (r_state == ST_CAPTURE) && aer_valid_i && !w_dup && w_full;
   assign w_ram_we     = w_start || w_cap_acc;
   assign w_xfer       = r_out_valid && core_ready_i;
   assign w_last_xfer  = w_xfer && (r_xfer_cnt == (r_count - 1'b1));
   // A read may issue whenever the output register is free by the next edge,
   // giving one transfer every two cycles with the 1-cycle RAM latency.
   assign w_rd_issue   = (r_state == ST_REPLAY) && !r_rd_pend &&
                         (!r_out_valid || core_ready_i) && (r_rd_ptr < r_count);
   assign w_class_ok   = ({1'b0, class_id_i} < c_ncls_v);
   assign w_timer_done = (r_timer == c_tmr_end);

   always_comb begin
      w_ram_addr = r_rd_ptr[ADDR_W-1:0];
      if (w_start) begin
         w_ram_addr = '0;
      end else if (r_state == ST_CAPTURE) begin
         w_ram_addr = r_count[ADDR_W-1:0];
      end
   end

   always_ff @(posedge work_clk) begin
      if (w_ram_we) begin
         r_mem[w_ram_addr] <= aer_data_i;
      end
      r_ram_q <= r_mem[w_ram_addr];
   end

   always_ff @(posedge work_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      core_rst_o       = 1'b0;
      prop_en_o        = 1'b0;
      busy_o           = 1'b1;
      result_valid_o   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            core_rst_o = 1'b1;
            busy_o     = 1'b0;
            if (aer_valid_i) w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (!aer_valid_i) w_state_nxt = ST_REPLAY;
         end
         ST_REPLAY: begin
            prop_en_o = 1'b1;
            if (w_last_xfer) w_state_nxt = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            prop_en_o = 1'b1;
            if (class_valid_i || w_timer_done) w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            result_valid_o = 1'b1;
            w_state_nxt    = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Outputs go to their reset values as soon as rst is seen.
      if (rst) begin
         core_rst_o     = 1'b1;
         prop_en_o      = 1'b0;
         busy_o         = 1'b0;
         result_valid_o = 1'b0;
      end
   end

   always_ff @(posedge work_clk) begin
      if (rst) begin
         r_count     <= '0;
         r_last      <= '0;
         r_overflow  <= 1'b0;
         r_timeout   <= 1'b0;
         r_result    <= '0;
         r_timer     <= '0;
         r_rd_ptr    <= '0;
         r_xfer_cnt  <= '0;
         r_rd_pend   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_start) begin
            r_count    <= CNT_W'(1);
            r_last     <= aer_data_i;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_rd_ptr   <= '0;
            r_xfer_cnt <= '0;
            r_timer    <= '0;
         end
         if (w_cap_acc) begin
            r_count <= r_count + 1'b1;
            r_last  <= aer_data_i;
         end
         if (w_cap_ovf) begin
            r_overflow <= 1'b1;
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_rd_pend <= w_rd_issue;
         if (r_rd_pend) begin
            r_out_data  <= r_ram_q;
            r_out_valid <= 1'b1;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
         end
         if (w_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
         end
         if (r_state == ST_WAIT_RES) begin
            r_timer <= r_timer + 1'b1;
            // The classifier wins over a timer expiring in the same cycle.
            if (class_valid_i) begin
               r_result <= w_class_ok ? RESULT_W'(class_id_i) : '0;
            end else if (w_timer_done) begin
               r_result  <= '1;
               r_timeout <= 1'b1;
            end
         end
      end
   end

   assign core_aer_o       = rst ? '0 : r_out_data;
   assign core_aer_valid_o = !rst && r_out_valid;
   assign result_o         = rst ? '0 : r_result;
   assign event_count_o    = rst ? '0 : r_count;
   assign overflow_o       = !rst && r_overflow;
   assign timeout_o        = !rst && r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_aer_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aer_frame_sequencer
//  Purpose  : Randomized scoreboard bench for aer_frame_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aer_frame_sequencer;

   localparam int DATA_W      = 16;
   localparam int ADDR_W      = 3;
   localparam int CLASS_W     = 2;
   localparam int NUM_CLASSES = 3;
   localparam int RESULT_W    = 32;
   localparam int TIMEOUT     = 20;
   localparam int DEPTH       = 1 << ADDR_W;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                aer_valid_i = 1'b0;
   logic [DATA_W-1:0]   aer_data_i = '0;
   logic                core_ready_i = 1'b1;
   logic                class_valid_i = 1'b0;
   logic [CLASS_W-1:0]  class_id_i = '0;
   logic                core_rst_o;
   logic                prop_en_o;
   logic [DATA_W-1:0]   core_aer_o;
   logic                core_aer_valid_o;
   logic [RESULT_W-1:0] result_o;
   logic                result_valid_o;
   logic [ADDR_W:0]     event_count_o;
   logic                overflow_o;
   logic                timeout_o;
   logic                busy_o;

   always #5 clk = ~clk;

   aer_frame_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W), .NUM_CLASSES(NUM_CLASSES),
      .RESULT_W(RESULT_W), .DEDUP(1), .TIMEOUT(TIMEOUT)
   ) dut (
      .work_clk(clk), .rst(rst), .aer_valid_i(aer_valid_i), .aer_data_i(aer_data_i),
      .core_rst_o(core_rst_o), .prop_en_o(prop_en_o), .core_aer_o(core_aer_o),
      .core_aer_valid_o(core_aer_valid_o), .core_ready_i(core_ready_i),
      .class_valid_i(class_valid_i), .class_id_i(class_id_i), .result_o(result_o),
      .result_valid_o(result_valid_o), .event_count_o(event_count_o),
      .overflow_o(overflow_o), .timeout_o(timeout_o), .busy_o(busy_o)
   );

   typedef struct packed {
      logic [RESULT_W-1:0] res;
      logic                to;
      logic                ov;
      logic [ADDR_W:0]     cnt;
   } exp_t;

   logic [DATA_W-1:0] exp_words[$];
   exp_t              exp_res[$];
   logic [DATA_W-1:0] frm[$];
   logic [DATA_W-1:0] acc[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_xfer_cyc = 0;
   int result_cyc = 0;
   int result_seen = 0;
   bit rnd_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ready pattern: constant 1 or a random 50% duty.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         core_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a word or a result.
   initial begin : monitor
      logic              stalled;
      logic [DATA_W-1:0] held;
      logic              busy_chk;
      exp_t              e;
      stalled  = 1'b0;
      held     = '0;
      busy_chk = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled  = 1'b0;
            busy_chk = 1'b0;
         end else begin
            if (busy_chk) begin
               chk("busy_after_out", busy_o, 0);
               busy_chk = 1'b0;
            end
            if (stalled) begin
               chk("stall_valid", core_aer_valid_o, 1);
               chk("stall_data", core_aer_o, held);
            end
            stalled = core_aer_valid_o && !core_ready_i;
            held    = core_aer_o;
            if (core_aer_valid_o && core_ready_i) begin
               last_xfer_cyc = cyc;
               if (exp_words.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_word: got %0h expected none", core_aer_o);
               end else begin
                  chk("replay_word", core_aer_o, exp_words.pop_front());
               end
            end
            if (result_valid_o) begin
               result_cyc = cyc;
               result_seen++;
               busy_chk = 1'b1;
               if (exp_res.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_result: got %0h expected none", result_o);
               end else begin
                  e = exp_res.pop_front();
                  chk("result", result_o, e.res);
                  chk("timeout_flag", timeout_o, e.to);
                  chk("overflow_flag", overflow_o, e.ov);
                  chk("event_count", event_count_o, e.cnt);
               end
            end
         end
      end
   end

   // Reference: first word always stored, later duplicates of the last stored
   // word dropped, anything beyond DEPTH dropped and flagged.
   task automatic model_frame(output bit ov);
      logic [DATA_W-1:0] last;
      acc.delete();
      ov = 1'b0;
      last = '0;
      foreach (frm[i]) begin
         if (i > 0 && frm[i] == last) continue;
         if (acc.size() == DEPTH) begin
            ov = 1'b1;
            continue;
         end
         acc.push_back(frm[i]);
         last = frm[i];
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("idle_timeout", busy_o, 0);
   endtask

   task automatic drive_frame();
      foreach (frm[i]) begin
         aer_valid_i = 1'b1;
         aer_data_i  = frm[i];
         tick();
      end
      aer_valid_i = 1'b0;
      aer_data_i  = DATA_W'($urandom);
   endtask

   task automatic run_frame(input bit to, input int cls, input int d, input bit noise);
      bit   ov;
      exp_t e;
      int   n;
      int   seen0;
      model_frame(ov);
      foreach (acc[i]) exp_words.push_back(acc[i]);
      e.res = to ? '1 : ((cls < NUM_CLASSES) ? RESULT_W'(cls) : '0);
      e.to  = to;
      e.ov  = ov;
      e.cnt = (ADDR_W + 1)'(acc.size());
      exp_res.push_back(e);
      wait_idle();
      seen0 = result_seen;
      drive_frame();
      n = 0;
      do begin
         tick();
         n++;
         if (noise && exp_words.size() != 0) begin
            aer_valid_i   = 1'($urandom_range(0, 1));
            aer_data_i    = DATA_W'($urandom);
            class_valid_i = 1'($urandom_range(0, 1));
            class_id_i    = CLASS_W'($urandom);
         end
      end while (exp_words.size() != 0 && n < 400);
      aer_valid_i   = 1'b0;
      class_valid_i = 1'b0;
      if (n >= 400) begin
         chk("replay_drained", exp_words.size(), 0);
         exp_words.delete();
      end
      if (!to) begin
         repeat (d) tick();
         class_valid_i = 1'b1;
         class_id_i    = CLASS_W'(cls);
         tick();
         class_valid_i = 1'b0;
      end
      n = 0;
      while (result_seen == seen0 && n < 100) begin
         tick();
         n++;
      end
      chk("result_arrived", result_seen != seen0, 1);
      if (result_seen == seen0) exp_res.delete();
      else if (to) chk("timeout_latency", result_cyc - last_xfer_cyc, TIMEOUT + 1);
   endtask

   task automatic run_abort();
      bit ov;
      int n;
      int seen0;
      model_frame(ov);
      foreach (acc[i]) exp_words.push_back(acc[i]);
      wait_idle();
      seen0 = result_seen;
      drive_frame();
      n = 0;
      while (exp_words.size() > acc.size() - 2 && n < 200) begin
         tick();
         n++;
      end
      rst = 1'b1;
      exp_words.delete();
      tick();
      tick();
      chk("abort_core_rst", core_rst_o, 1);
      chk("abort_busy", busy_o, 0);
      chk("abort_count", event_count_o, 0);
      chk("abort_aer_valid", core_aer_valid_o, 0);
      chk("abort_prop_en", prop_en_o, 0);
      rst = 1'b0;
      repeat (30) tick();
      chk("abort_no_result", result_seen, seen0);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_core_rst", core_rst_o, 1);
      chk("rst_prop_en", prop_en_o, 0);
      chk("rst_aer_valid", core_aer_valid_o, 0);
      chk("rst_aer_data", core_aer_o, 0);
      chk("rst_result_valid", result_valid_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_count", event_count_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_busy", busy_o, 0);
      rst = 1'b0;
      tick();

      frm = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
      run_frame(1'b0, 2, 3, 1'b0);

      frm = '{16'h1234, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 16'h0042};
      run_frame(1'b0, 1, 0, 1'b0);

      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(DATA_W'(16'h0100 + i));
      run_frame(1'b0, 0, 5, 1'b0);

      frm = '{16'hA001, 16'hA002, 16'hA003};
      run_frame(1'b1, 0, 0, 1'b0);

      frm = '{16'h0007, 16'h0008};
      run_frame(1'b0, 3, 2, 1'b0);

      frm = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
      run_frame(1'b0, 1, TIMEOUT - 1, 1'b0);

      rnd_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         int len;
         len = $urandom_range(1, 11);
         frm.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) frm.push_back(DATA_W'($urandom_range(0, 3)));
            else frm.push_back(DATA_W'($urandom));
         end
         run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 3),
                   $urandom_range(0, TIMEOUT - 1), 1'b1);
      end

      frm = '{16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005, 16'hD006};
      run_abort();

      frm = '{16'hE001, 16'hE002, 16'hE003};
      run_frame(1'b0, 2, 1, 1'b1);

      chk("words_left", exp_words.size(), 0);
      chk("results_left", exp_res.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
`default_nettype wire

// File: doc/aer_frame_sequencer.md
AER_FRAME_SEQUENCER -- requirements
Module: aer_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: AER event word width.
REQ-002 SHALL have parameter ADDR_W, default 14: frame buffer address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter CLASS_W, default 2: classifier result width.
REQ-004 SHALL have parameter NUM_CLASSES, default 3: legal class ids are 0..NUM_CLASSES-1.
REQ-005 SHALL have parameter RESULT_W, default 32: result bus width, at least CLASS_W.
REQ-006 SHALL have parameter DEDUP, default 1: 1 = drop a word equal to the previous accepted word.
REQ-007 SHALL have parameter TIMEOUT, default 65535: cycle limit in WAIT_RES before a timeout result is issued.
REQ-008 SHALL have port work_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port aer_valid_i, input, 1 bit: frame-active level; 1 = aer_data_i holds an event.
REQ-011 SHALL have port aer_data_i, input, DATA_W bits: incoming AER event word.
REQ-012 SHALL have port core_rst_o, output, 1 bit: active-high reset to the SCNN core.
REQ-013 SHALL have port prop_en_o, output, 1 bit: propagation enable to the SCNN core.
REQ-014 SHALL have port core_aer_o, output, DATA_W bits: replayed event word.
REQ-015 SHALL have port core_aer_valid_o, output, 1 bit: core_aer_o is valid.
REQ-016 SHALL have port core_ready_i, input, 1 bit: the core accepts a word (0 = core input FIFO full).
REQ-017 SHALL have port class_valid_i, input, 1 bit: single-cycle classifier done pulse.
REQ-018 SHALL have port class_id_i, input, CLASS_W bits: classifier result.
REQ-019 SHALL have port result_o, output, RESULT_W bits: frame result.
REQ-020 SHALL have port result_valid_o, output, 1 bit: single-cycle result strobe.
REQ-021 SHALL have port event_count_o, output, ADDR_W+1 bits: number of words stored for the current frame.
REQ-022 SHALL have port overflow_o, output, 1 bit: sticky flag, frame exceeded DEPTH.
REQ-023 SHALL have port timeout_o, output, 1 bit: sticky flag, the last result was produced by timeout.
REQ-024 SHALL have port busy_o, output, 1 bit: 1 in every state except IDLE.

Function
REQ-025 SHALL implement states IDLE, CAPTURE, REPLAY, WAIT_RES and OUT, with transitions registered on work_clk.
REQ-026 IDLE SHALL hold core_rst_o=1 and prop_en_o=0; aer_valid_i=1 SHALL write aer_data_i to address 0, set event_count_o=1, clear overflow_o and timeout_o, and move to CAPTURE.
REQ-027 CAPTURE SHALL hold core_rst_o=0 and prop_en_o=0.
REQ-028 In CAPTURE, each cycle with aer_valid_i=1 SHALL write the word at address event_count_o and increment the count, unless DEDUP=1 and the word equals the last accepted word.
REQ-029 When event_count_o equals DEPTH, further words SHALL be dropped, the count SHALL saturate at DEPTH, and overflow_o SHALL be set.
REQ-030 In CAPTURE, aer_valid_i=0 SHALL move to REPLAY; a word of value 0 is a legal event and SHALL NOT end the frame.
REQ-031 REPLAY SHALL hold prop_en_o=1 and present stored words from address 0 to event_count_o-1 in order on core_aer_o with a valid/ready handshake.
REQ-032 A word transfers only in a cycle with core_aer_valid_o=1 and core_ready_i=1; core_aer_o SHALL be held stable while core_aer_valid_o=1 and core_ready_i=0.
REQ-033 The first core_aer_valid_o SHALL assert no later than 2 cycles after REPLAY is entered.
REQ-034 While core_ready_i is held at 1, REPLAY SHALL sustain at least one transfer per 2 cycles.
REQ-035 Exactly event_count_o transfers SHALL occur; after the last one the block SHALL move to WAIT_RES with core_aer_valid_o=0.
REQ-036 WAIT_RES SHALL hold prop_en_o=1 and count cycles.
REQ-037 In WAIT_RES, class_valid_i=1 SHALL move to OUT with result_o = class_id_i zero-extended to RESULT_W when class_id_i < NUM_CLASSES, else 0.
REQ-038 In WAIT_RES, a count reaching TIMEOUT without class_valid_i SHALL move to OUT with result_o = all ones and timeout_o set.
REQ-039 If class_valid_i arrives in the same cycle the timeout expires, class_valid_i SHALL take priority.
REQ-040 OUT SHALL pulse result_valid_o for exactly one cycle, drive prop_en_o=0, and return to IDLE on the next cycle.
REQ-041 result_o SHALL hold its value until the next result.
REQ-042 class_valid_i SHALL be ignored in every state except WAIT_RES.
REQ-043 aer_valid_i SHALL be ignored in REPLAY, WAIT_RES and OUT; a new frame starts only from IDLE.
REQ-044 The frame buffer SHALL be a single-port synchronous RAM of DEPTH x DATA_W with 1-cycle read latency, inferred rather than vendor IP.

Reset
REQ-045 While rst=1 the block SHALL enter IDLE with core_rst_o=1, all other outputs 0, and event_count_o, the timer and the read/write pointers cleared.
REQ-046 rst=1 asserted in any state, including mid-replay, SHALL abort the frame with no result_valid_o pulse.
REQ-047 Buffer contents need not be cleared by reset.

Verification
REQ-048 Frame of 5 distinct words, core_ready_i=1, class_id_i=2 after replay -> 5 transfers in order, result_o=2, result_valid_o one cycle, busy_o falls on the next cycle.
REQ-049 DEDUP=1, input A,A,B,0,0,C -> event_count_o=4 and replay is A,B,0,C.
REQ-050 ADDR_W=3, frame of 10 words -> event_count_o=8, overflow_o=1, first 8 words replayed.
REQ-051 core_ready_i toggled with a random 50% duty -> no word lost or duplicated, and core_aer_o stable while stalled.
REQ-052 TIMEOUT=20 and no class_valid_i -> result_o=0xFFFFFFFF and timeout_o=1 at 20 cycles into WAIT_RES.
REQ-053 class_id_i=3 with NUM_CLASSES=3 -> result_o=0; rst pulsed during REPLAY -> IDLE, no result_valid_o.
